// File: rtl/spectrum_frame_seq.sv
// Frame sequencer for the FFT spectrum path: frames ADC samples into the FFT input stream and
// turns per-bin heights into display RAM writes using live, peak-hold or averaging modes.
module spectrum_frame_seq #(
  parameter int POINTS     = 1024,
  parameter int SAMPLE_W   = 8,
  parameter int FFT_IN_W   = 16,
  parameter int HEIGHT_W   = 8,
  parameter int GAP_CYCLES = 24000,
  parameter int AVG_SHIFT  = 2,
  parameter int AW         = $clog2(POINTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cfg_continuous,
  input  logic [1:0]          cfg_mode,
  input  logic                clear_hold,
  input  logic                smp_valid,
  output logic                smp_ready,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic [FFT_IN_W-1:0] fft_tdata,
  output logic                fft_tvalid,
  input  logic                fft_tready,
  output logic                fft_tlast,
  input  logic                res_valid,
  input  logic [AW-1:0]       res_index,
  input  logic [HEIGHT_W-1:0] res_height,
  input  logic                res_last,
  output logic                disp_wr_en,
  output logic [AW-1:0]       disp_wr_addr,
  output logic [HEIGHT_W-1:0] disp_wr_data,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic                err
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [AW:0]    NumPts  = (AW+1)'(POINTS);
  localparam logic [AW:0]    LastIdx = (AW+1)'(POINTS - 1);
  localparam logic [GW-1:0]  GapLast = GW'(GAP_CYCLES - 1);
  localparam logic [1:0]     ModeLive = 2'b00;
  localparam logic [1:0]     ModePeak = 2'b01;
  localparam logic [1:0]     ModeAvg  = 2'b10;

  typedef enum logic [1:0] {StIdle, StFeed, StCollect, StGap} state_e;

  state_e              state_q;
  logic [AW:0]         feed_cnt_q, res_cnt_q;
  logic [GW-1:0]       gap_cnt_q;
  logic [1:0]          mode_q;
  logic                hist_ok_q, clear_pend_q, collecting_q;
  logic                s1_valid_q;
  logic [AW-1:0]       s1_index_q;
  logic [HEIGHT_W-1:0] s1_height_q, old_q;
  logic                tvalid_q, tlast_q;
  logic [FFT_IN_W-1:0] tdata_q;
  logic                wr_en_q;
  logic [AW-1:0]       wr_addr_q;
  logic [HEIGHT_W-1:0] wr_data_q;
  logic                frame_done_q, err_q;
  logic [15:0]         frame_cnt_q;

  logic [HEIGHT_W-1:0] hist [POINTS];

  logic                smp_acc, res_acc, feed_entry;
  logic [1:0]          cfg_eff;
  logic [FFT_IN_W-1:0] smp_signed;
  logic signed [HEIGHT_W:0] avg_diff, avg_step;
  logic [HEIGHT_W:0]   avg_sum;
  logic [HEIGHT_W-1:0] mode_out;

  assign smp_ready  = (state_q == StFeed) && (feed_cnt_q < NumPts) && (!tvalid_q || fft_tready);
  assign smp_acc    = smp_valid && smp_ready;
  assign res_acc    = res_valid && (state_q == StCollect) && collecting_q;
  assign cfg_eff    = (cfg_mode == 2'b11) ? ModeLive : cfg_mode;
  assign feed_entry = ((state_q == StIdle) && start) ||
                      ((state_q == StGap) && (gap_cnt_q == GapLast) && cfg_continuous);
  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  assign smp_signed = {{(FFT_IN_W-SAMPLE_W){~smp_data[SAMPLE_W-1]}},
                       ~smp_data[SAMPLE_W-1], smp_data[SAMPLE_W-2:0]};

  always_comb begin
    avg_diff = $signed({1'b0, s1_height_q}) - $signed({1'b0, old_q});
    avg_step = avg_diff >>> AVG_SHIFT;
    avg_sum  = {1'b0, old_q} + $unsigned(avg_step);
    mode_out = s1_height_q;
    if (hist_ok_q) begin
      case (mode_q)
        ModePeak: mode_out = (s1_height_q > old_q) ? s1_height_q : old_q;
        ModeAvg:  mode_out = avg_sum[HEIGHT_W-1:0];
        default:  mode_out = s1_height_q;
      endcase
    end
  end

  // History is never reset; hist_ok_q decides whether its contents are trusted.
  always_ff @(posedge clk) begin
    if (!rst && s1_valid_q) hist[s1_index_q] <= mode_out;
    old_q <= hist[res_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      feed_cnt_q   <= '0;
      res_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      mode_q       <= ModeLive;
      hist_ok_q    <= 1'b0;
      clear_pend_q <= 1'b0;
      collecting_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_index_q   <= '0;
      s1_height_q  <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      wr_en_q      <= s1_valid_q;
      if (s1_valid_q) begin
        wr_addr_q <= s1_index_q;
        wr_data_q <= mode_out;
      end
      if (clear_hold) clear_pend_q <= 1'b1;
      if (feed_entry) begin
        feed_cnt_q   <= '0;
        mode_q       <= cfg_eff;
        clear_pend_q <= 1'b0;
        if (clear_pend_q || clear_hold || (cfg_eff != mode_q)) hist_ok_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFeed;
            err_q   <= 1'b0;
          end
        end
        StFeed: begin
          if (smp_acc) begin
            tdata_q    <= smp_signed;
            tvalid_q   <= 1'b1;
            tlast_q    <= (feed_cnt_q == LastIdx);
            feed_cnt_q <= feed_cnt_q + (AW+1)'(1);
          end else if (tvalid_q && fft_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (tlast_q) begin
              state_q      <= StCollect;
              collecting_q <= 1'b1;
              res_cnt_q    <= '0;
            end
          end
        end
        StCollect: begin
          if (!collecting_q && !s1_valid_q) begin
            state_q      <= StGap;
            gap_cnt_q    <= '0;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
            hist_ok_q    <= 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) state_q <= cfg_continuous ? StFeed : StIdle;
          else gap_cnt_q <= gap_cnt_q + GW'(1);
        end
        default: state_q <= StIdle;
      endcase
      s1_valid_q <= res_acc;
      if (res_acc) begin
        s1_index_q  <= res_index;
        s1_height_q <= res_height;
        res_cnt_q   <= res_cnt_q + (AW+1)'(1);
        // Collection ends on res_last or on the POINTS-th beat, whichever comes first.
        if (res_last || (res_cnt_q == LastIdx)) begin
          collecting_q <= 1'b0;
          if (res_last != (res_cnt_q == LastIdx)) err_q <= 1'b1;
        end
      end else if (res_valid) begin
        err_q <= 1'b1;
      end
    end
  end

  assign fft_tdata    = tdata_q;
  assign fft_tvalid   = tvalid_q;
  assign fft_tlast    = tlast_q;
  assign disp_wr_en   = wr_en_q;
  assign disp_wr_addr = wr_addr_q;
  assign disp_wr_data = wr_data_q;
  assign busy         = (state_q != StIdle);
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_spectrum_frame_seq.sv
// Directed bench for spectrum_frame_seq with 16-point frames: sample framing, display modes,
// protocol errors and reset recovery, with hand-computed expectations.
module tb_spectrum_frame_seq;
  localparam int Points = 16;
  localparam int Gap    = 5;

  logic        clk = 1'b0;
  logic        rst, start, cfg_continuous, clear_hold;
  logic [1:0]  cfg_mode;
  logic        smp_valid, smp_ready;
  logic [7:0]  smp_data;
  logic [15:0] fft_tdata;
  logic        fft_tvalid, fft_tready, fft_tlast;
  logic        res_valid, res_last;
  logic [3:0]  res_index;
  logic [7:0]  res_height;
  logic        disp_wr_en;
  logic [3:0]  disp_wr_addr;
  logic [7:0]  disp_wr_data;
  logic        busy, frame_done, err;
  logic [15:0] frame_cnt;

  spectrum_frame_seq #(
    .POINTS(Points), .SAMPLE_W(8), .FFT_IN_W(16), .HEIGHT_W(8),
    .GAP_CYCLES(Gap), .AVG_SHIFT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_continuous(cfg_continuous),
    .cfg_mode(cfg_mode), .clear_hold(clear_hold), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .smp_data(smp_data), .fft_tdata(fft_tdata),
    .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tlast(fft_tlast),
    .res_valid(res_valid), .res_index(res_index), .res_height(res_height),
    .res_last(res_last), .disp_wr_en(disp_wr_en), .disp_wr_addr(disp_wr_addr),
    .disp_wr_data(disp_wr_data), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;
  int hts[Points];
  int exp_h[Points];

  logic [16:0]  fft_q[$];
  logic [11:0]  wr_q[$];
  int unsigned  wr_cyc[$];
  logic         stall_prev = 1'b0;
  logic [16:0]  held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Monitors sample on the falling edge; bench-side checks run 1 time unit later.
  always @(negedge clk) begin
    if (disp_wr_en === 1'b1) begin
      wr_q.push_back({disp_wr_addr, disp_wr_data});
      wr_cyc.push_back(cyc);
    end
    if (fft_tvalid === 1'b1 && fft_tready === 1'b1) fft_q.push_back({fft_tlast, fft_tdata});
    if (stall_prev) begin
      check_eq("hold_valid", fft_tvalid, 1);
      check_eq("hold_beat", {fft_tlast, fft_tdata}, held);
    end
    if (fft_tvalid === 1'b1 && fft_tready === 1'b0) check_eq("ready_when_full", smp_ready, 0);
    stall_prev <= (fft_tvalid === 1'b1 && fft_tready === 1'b0);
    held       <= {fft_tlast, fft_tdata};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input string tag, input int first, input bit rand_ready);
    int sent = 0;
    int guard = 0;
    smp_valid = 1'b1;
    smp_data  = 8'(first);
    while (sent < Points && guard < 400) begin
      fft_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (smp_ready) sent++;
      step();
      smp_data = 8'(first + sent);
      guard++;
    end
    smp_valid  = 1'b0;
    fft_tready = 1'b1;
    check_eq({tag, ".fed"}, sent, Points);
    guard = 0;
    while (guard < 50) begin
      @(negedge clk);
      if (!fft_tvalid) break;
      step();
      guard++;
    end
    check_eq({tag, ".drain"}, fft_tvalid, 0);
    step();
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while (guard < 40) begin
      @(negedge clk);
      #1;
      if (frame_done) break;
      guard++;
    end
    check_eq({tag, ".done"}, frame_done, 1);
  endtask

  task automatic run_frame(input string tag, input int first, input bit rand_ready,
                           input bit reverse, input bit extra);
    int idx;
    int unsigned c0;
    logic [16:0] e17;
    logic [11:0] e12;
    wr_q.delete();
    wr_cyc.delete();
    fft_q.delete();
    feed(tag, first, rand_ready);
    check_eq({tag, ".fft_n"}, fft_q.size(), Points);
    for (int i = 0; i < Points && i < fft_q.size(); i++) begin
      e17 = {(i == Points - 1), 16'(((first + i) & 255) - 128)};
      check_eq($sformatf("%s.fft%0d", tag, i), fft_q[i], e17);
    end
    c0 = cyc;
    for (int i = 0; i < Points; i++) begin
      idx        = reverse ? Points - 1 - i : i;
      res_valid  = 1'b1;
      res_index  = 4'(idx);
      res_height = 8'(hts[idx]);
      res_last   = (i == Points - 1);
      step();
    end
    if (extra) begin
      res_index  = 4'd5;
      res_height = 8'd77;
      res_last   = 1'b0;
      step();
    end
    res_valid = 1'b0;
    res_last  = 1'b0;
    wait_done(tag);
    exp_frames++;
    check_eq({tag, ".frame_cnt"}, frame_cnt, exp_frames);
    check_eq({tag, ".wr_n"}, wr_q.size(), Points);
    for (int i = 0; i < Points && i < wr_q.size(); i++) begin
      idx = reverse ? Points - 1 - i : i;
      e12 = {4'(idx), 8'(exp_h[idx])};
      check_eq($sformatf("%s.wr%0d", tag, i), wr_q[i], e12);
    end
    if (wr_cyc.size() > 0) check_eq({tag, ".wr_lat"}, wr_cyc[0], c0 + 2);
  endtask

  task automatic gap_check(input string tag, input bit rearm);
    for (int k = 1; k <= Gap; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) check_eq({tag, ".done_pulse"}, frame_done, 0);
      if (k == Gap - 1) begin
        check_eq({tag, ".gap_busy"}, busy, 1);
        check_eq({tag, ".gap_rdy"}, smp_ready, 0);
      end
      if (k == Gap) begin
        if (rearm) begin
          check_eq({tag, ".rearm_busy"}, busy, 1);
          check_eq({tag, ".rearm_rdy"}, smp_ready, 1);
        end else begin
          check_eq({tag, ".idle"}, busy, 0);
        end
      end
    end
    step();
  endtask

  task automatic set_all(input int h, input int e);
    for (int i = 0; i < Points; i++) begin
      hts[i]   = h;
      exp_h[i] = e;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_continuous = 1'b0; clear_hold = 1'b0; cfg_mode = 2'b00;
    smp_valid = 1'b0; smp_data = '0; fft_tready = 1'b1;
    res_valid = 1'b0; res_index = '0; res_height = '0; res_last = 1'b0;
    step();
    step();
    check_eq("rst.smp_ready", smp_ready, 0);
    check_eq("rst.tvalid", fft_tvalid, 0);
    check_eq("rst.tlast", fft_tlast, 0);
    check_eq("rst.tdata", fft_tdata, 0);
    check_eq("rst.wr_en", disp_wr_en, 0);
    check_eq("rst.wr_addr", disp_wr_addr, 0);
    check_eq("rst.wr_data", disp_wr_data, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", frame_done, 0);
    check_eq("rst.frame_cnt", frame_cnt, 0);
    check_eq("rst.err", err, 0);
    rst = 1'b0;
    step();

    // Live single shot, ramp samples 0..15.
    for (int i = 0; i < Points; i++) begin
      hts[i]   = i * 7 + 1;
      exp_h[i] = i * 7 + 1;
    end
    pulse_start();
    check_eq("live.busy", busy, 1);
    run_frame("live", 0, 0, 0, 0);
    check_eq("live.err", err, 0);
    gap_check("live", 0);

    // Live with random FFT backpressure.
    for (int i = 0; i < Points; i++) begin
      hts[i]   = 200 - i * 9;
      exp_h[i] = 200 - i * 9;
    end
    pulse_start();
    run_frame("stall", 100, 1, 0, 0);
    gap_check("stall", 0);

    // Peak hold: 200 then 50 keeps 200; clear_hold forces raw 50.
    cfg_mode = 2'b01;
    set_all(10, 10);
    hts[3] = 200; exp_h[3] = 200;
    pulse_start();
    run_frame("peak_a", 20, 0, 0, 0);
    gap_check("peak_a", 0);
    set_all(5, 10);
    hts[3] = 50; exp_h[3] = 200;
    pulse_start();
    run_frame("peak_b", 30, 0, 0, 0);
    gap_check("peak_b", 0);
    clear_hold = 1'b1;
    step();
    clear_hold = 1'b0;
    set_all(5, 5);
    hts[3] = 50; exp_h[3] = 50;
    pulse_start();
    run_frame("peak_c", 40, 0, 0, 0);
    gap_check("peak_c", 0);

    // Average with shift 2: old + ((h - old) >>> 2).
    cfg_mode = 2'b10;
    set_all(100, 100);
    hts[0] = 0;   exp_h[0] = 0;
    hts[1] = 255; exp_h[1] = 255;
    pulse_start();
    run_frame("avg_d", 50, 0, 0, 0);
    gap_check("avg_d", 0);
    hts[0] = 255; exp_h[0] = 63;
    hts[1] = 3;   exp_h[1] = 192;
    pulse_start();
    run_frame("avg_e", 60, 0, 0, 0);
    gap_check("avg_e", 0);
    exp_h[0] = 111;
    exp_h[1] = 144;
    pulse_start();
    run_frame("avg_f", 70, 0, 0, 0);
    gap_check("avg_f", 0);

    // Protocol errors: beat in IDLE, reverse order, surplus beat after res_last.
    cfg_mode = 2'b00;
    wr_q.delete();
    res_valid = 1'b1; res_index = 4'd2; res_height = 8'd9;
    step();
    res_valid = 1'b0;
    step();
    step();
    check_eq("idle_beat.err", err, 1);
    check_eq("idle_beat.no_wr", wr_q.size(), 0);
    pulse_start();
    check_eq("start.err_clr", err, 0);
    for (int i = 0; i < Points; i++) begin
      hts[i]   = 255 - 3 * i;
      exp_h[i] = 255 - 3 * i;
    end
    run_frame("err", 7, 0, 1, 1);
    check_eq("err.sticky", err, 1);
    gap_check("err", 0);

    // Reset mid-FEED, then continuous peak frames.
    cfg_mode = 2'b01;
    pulse_start();
    smp_valid = 1'b1;
    smp_data  = 8'd9;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp_valid = 1'b0;
    check_eq("midrst.busy", busy, 0);
    check_eq("midrst.tvalid", fft_tvalid, 0);
    check_eq("midrst.frame_cnt", frame_cnt, 0);
    check_eq("midrst.err", err, 0);
    exp_frames = 0;
    cfg_continuous = 1'b1;
    set_all(1, 1);
    pulse_start();
    run_frame("cont1", 40, 0, 0, 0);
    gap_check("cont1", 1);
    cfg_continuous = 1'b0;
    set_all(0, 1);
    run_frame("cont2", 60, 0, 0, 0);
    gap_check("cont2", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
